// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a small TX FIFO that a
// baud-rate FSM drains onto uart_tx. Status is read back combinationally.
module io_uart_tx #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic        uart_tx
);

  localparam int DIV    = CLK_FREQ_HZ / BAUD;
  localparam int BCNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST  = BCNT_W'(DIV - 1);
  localparam logic [CW-1:0]     COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [BCNT_W-1:0]  bcnt_reg;
  logic [2:0]         bidx_reg;
  logic [7:0]         sh_reg;
  logic               tx_reg;

  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic               ovf_reg;

  // Address decode: only word index bits [15:2] take part.
  logic [13:0] word_idx;
  logic        sel_data;
  logic        sel_ctrl;
  assign word_idx = IO_mem_addr[15:2];
  assign sel_data = (word_idx == 14'd2);
  assign sel_ctrl = (word_idx == 14'd3);

  logic unused_bits;
  assign unused_bits = ^{IO_mem_addr[31:16], IO_mem_addr[1:0], IO_mem_wdata[31:8]};

  logic fifo_empty;
  logic fifo_full;
  logic baud_last;
  logic wr_data;
  logic push;
  logic pop;
  logic drop;
  logic ctrl_clr;
  logic [7:0] pop_data;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == COUNT_FULL);
  assign baud_last  = (bcnt_reg == BCNT_LAST);
  assign wr_data    = IO_mem_wr && sel_data;
  // Fullness is judged on the registered count, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign push       = wr_data && !fifo_full;
  assign drop       = wr_data && fifo_full;
  assign ctrl_clr   = IO_mem_wr && sel_ctrl && IO_mem_wdata[0];
  assign pop        = !fifo_empty &&
                      ((state_reg == S_IDLE) || ((state_reg == S_STOP) && baud_last));
  assign pop_data   = fifo_mem[rd_ptr_reg];

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= IO_mem_wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) begin
        ovf_reg <= 1'b1;
      end else if (ctrl_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      bcnt_reg  <= '0;
      bidx_reg  <= '0;
      sh_reg    <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            sh_reg    <= pop_data;
            bcnt_reg  <= '0;
            tx_reg    <= 1'b0;
            state_reg <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            bcnt_reg  <= '0;
            bidx_reg  <= '0;
            tx_reg    <= sh_reg[0];
            state_reg <= S_DATA;
          end else begin
            bcnt_reg <= bcnt_reg + BCNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            bcnt_reg <= '0;
            sh_reg   <= sh_reg >> 1;
            if (bidx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= S_STOP;
            end else begin
              bidx_reg <= bidx_reg + 3'd1;
              tx_reg   <= sh_reg[1];
            end
          end else begin
            bcnt_reg <= bcnt_reg + BCNT_W'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            bcnt_reg <= '0;
            // Chain straight into the next start bit when data is waiting.
            if (pop) begin
              sh_reg    <= pop_data;
              tx_reg    <= 1'b0;
              state_reg <= S_START;
            end else begin
              tx_reg    <= 1'b1;
              state_reg <= S_IDLE;
            end
          end else begin
            bcnt_reg <= bcnt_reg + BCNT_W'(1);
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  logic        busy;
  logic [31:0] count_ext;
  logic [3:0]  count_disp;
  logic [31:0] status_word;

  assign busy        = (state_reg != S_IDLE) || !fifo_empty;
  assign count_ext   = 32'(count_reg);
  assign count_disp  = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status_word = {21'd0, ovf_reg, fifo_full, busy, 4'd0, count_disp};

  assign IO_mem_rdata = (sel_data || sel_ctrl) ? status_word : 32'd0;
  assign uart_tx      = tx_reg;

endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx: register vectors, exact line timing,
// FIFO overflow and asynchronous reset, with a frame-decoding scoreboard.
module tb_io_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 8;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        wr = 1'b0;
  logic [31:0] rdata;
  logic        tx;

  always #5 clk = ~clk;

  io_uart_tx #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .IO_mem_addr(addr),
    .IO_mem_wdata(wdata),
    .IO_mem_wr(wr),
    .IO_mem_rdata(rdata),
    .uart_tx(tx)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_frames = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line monitor: samples each bit at its centre and checks against the scoreboard.
  int         m_cnt = 0;
  logic       m_act = 1'b0;
  logic [7:0] m_sh = 8'h00;
  always @(negedge clk) begin
    if (!resetn) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (tx == 1'b0) begin
        m_act = 1'b1;
        m_cnt = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == DIV / 2) begin
        check("mon_start_bit", 32'(tx), 32'd0);
      end else if (m_cnt > DIV / 2 && m_cnt < DIV / 2 + 9 * DIV && (m_cnt - DIV / 2) % DIV == 0) begin
        m_sh = {tx, m_sh[7:1]};
      end else if (m_cnt == DIV / 2 + 9 * DIV) begin
        check("mon_stop_bit", 32'(tx), 32'd1);
        n_frames++;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mon_spurious_frame: got byte 0x%02h, expected no frame", m_sh);
        end else begin
          logic [7:0] exp_b;
          exp_b = sb_q.pop_front();
          check("mon_byte", 32'(m_sh), 32'(exp_b));
        end
        $display("frame %0d: byte 0x%02h at t=%0t", n_frames, m_sh, $time);
        m_act = 1'b0;
      end
    end
  end

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    wr    = 1'b1;
  endtask

  task automatic io_idle();
    @(negedge clk);
    wr    = 1'b0;
    wdata = 32'd0;
    addr  = 32'h8;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    io_write(32'h8, {24'd0, b});
    sb_q.push_back(b);
  endtask

  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  // Entered just after the negedge of the frame's first cycle; leaves at the
  // same phase of the cycle following the stop bit.
  task automatic expect_frame(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      check("line_bit", 32'(tx), 32'(bits[i / DIV]));
      addr = 32'h8;
      #1;
      check("busy_bit", rdata & 32'h100, 32'h100);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    addr = 32'h8;
    #1;
    while (k < max_cycles && rdata !== 32'd0) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_idle", rdata, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        sb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames_before;
    int low_cycles;

    // Reset
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    read_chk("reset_rdata", 32'h8, 32'd0);

    // Register decode vectors; exp is rdata before the edge that samples the entry.
    vecs[0]  = '{32'h0000_0000, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[1]  = '{32'h0000_0004, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[2]  = '{32'h0000_000C, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[3]  = '{32'h0000_0004, 32'h5A, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{32'h0000_0008, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[5]  = '{32'h0000_000C, 32'h1,  1'b1, 1'b0, 32'h0};
    vecs[6]  = '{32'h0000_0014, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[7]  = '{32'h0000_0008, 32'h77, 1'b1, 1'b1, 32'h0};
    vecs[8]  = '{32'h0000_0008, 32'h0,  1'b0, 1'b0, 32'h101};
    vecs[9]  = '{32'h0000_000C, 32'h0,  1'b0, 1'b0, 32'h100};
    vecs[10] = '{32'hFFFF_000C, 32'h0,  1'b0, 1'b0, 32'h100};
    vecs[11] = '{32'h0000_FFF8, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[12] = '{32'h0000_0003, 32'h0,  1'b0, 1'b0, 32'h0};
    vecs[13] = '{32'h0001_0008, 32'h0,  1'b0, 1'b0, 32'h100};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      addr  = vecs[i].addr;
      wdata = vecs[i].wdata;
      wr    = vecs[i].wr;
      #1;
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
      if (vecs[i].sb) sb_q.push_back(vecs[i].wdata[7:0]);
    end
    io_idle();
    wait_idle(2 * FRAME);

    // Single byte with exact line timing
    send_byte(8'h55);
    io_idle();
    check("single_tx_before_pop", 32'(tx), 32'd1);
    read_chk("single_count1", 32'h8, 32'h101);
    @(negedge clk);
    #1;
    expect_frame(8'h55);
    check("single_tx_after", 32'(tx), 32'd1);
    read_chk("single_done", 32'h8, 32'd0);

    // Back-to-back, second write lands on the pop cycle
    send_byte(8'h41);
    send_byte(8'h42);
    io_idle();
    check("b2b_start_low", 32'(tx), 32'd0);
    read_chk("pushpop_count", 32'h8, 32'h101);
    expect_frame(8'h41);
    expect_frame(8'h42);
    check("b2b_tx_after", 32'(tx), 32'd1);
    read_chk("b2b_done", 32'h8, 32'd0);

    // Fill and overflow
    frames_before = n_frames;
    for (int j = 0; j < 9; j++) send_byte(8'h30 + 8'(j));
    io_write(32'h8, 32'h39);
    io_idle();
    read_chk("ovf_status", 32'h8, 32'h708);
    read_chk("ovf_status_ctrl", 32'hC, 32'h708);
    io_write(32'hC, 32'h1);
    io_idle();
    read_chk("ovf_cleared", 32'h8, 32'h308);
    wait_idle(12 * FRAME);
    check("ovf_frames", 32'(n_frames - frames_before), 32'd9);
    check("ovf_sb_empty", 32'(sb_q.size()), 32'd0);

    // Asynchronous reset during data bit 3
    send_byte(8'hA5);
    send_byte(8'h3C);
    io_idle();
    repeat (44) @(negedge clk);
    #1;
    check("pre_reset_bit3", 32'(tx), 32'd0);
    read_chk("pre_reset_status", 32'h8, 32'h101);
    resetn = 1'b0;
    #1;
    check("async_reset_tx", 32'(tx), 32'd1);
    check("async_reset_rdata", rdata, 32'd0);
    sb_q.delete();
    frames_before = n_frames;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    low_cycles = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_cycles++;
    end
    #1;
    check("post_reset_line_idle", 32'(low_cycles), 32'd0);
    check("post_reset_frames", 32'(n_frames - frames_before), 32'd0);
    read_chk("post_reset_status", 32'h8, 32'd0);

    check("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
